// File: rtl/lbi_pkg.sv
// lbi_pkg: shared state encoding, defaults and helpers for the LBI row-hash engine.
// Used by lbi_adder_tree and lbi_row_hash (optional feature macro: LBIROW_STALLCNT_EN).
package lbi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEF_CHUNK = 16;
    localparam int DEF_OUTW  = 6;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lbi_adder_tree.sv
// lbi_adder_tree: masked, balanced combinational adder tree of CHUNK leaves.
// All partial sums are kept OUTW bits wide; the result is only needed mod 2^OUTW.
module lbi_adder_tree
    import lbi_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK,
    parameter int OUTW  = DEF_OUTW
) (
    input  logic [CHUNK-1:0]      mask,
    input  logic [CHUNK*OUTW-1:0] leaves,
    output logic [OUTW-1:0]       sum
);

    // Leaf count rounded up to a power of two; missing leaves read as 0.
    localparam int LV = clog2(CHUNK);
    localparam int NP = 1 << LV;

    for (genvar l = 0; l <= LV; l++) begin : g_lv
        logic [OUTW-1:0] s [NP >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NP; i++) begin : g_i
                if (i < CHUNK) begin : g_real
                    assign s[i] = mask[i] ? leaves[i*OUTW +: OUTW] : '0;
                end else begin : g_pad
                    assign s[i] = '0;
                end
            end
        end else begin : g_add
            for (genvar i = 0; i < (NP >> l); i++) begin : g_i
                assign s[i] = g_lv[l-1].s[2*i] + g_lv[l-1].s[2*i+1];
            end
        end
    end

    assign sum = g_lv[LV].s[0];

endmodule

// File: rtl/lbi_row_hash.sv
// lbi_row_hash: multi-row LBI row-hash engine, CHUNK message bits per round.
// Optional macro LBIROW_STALLCNT_EN adds a saturating stall_cnt[15:0] output.
module lbi_row_hash
    import lbi_pkg::*;
#(
    parameter int INPUTSIZE = 840,
    parameter int CHUNK     = DEF_CHUNK,
    parameter int OUTW      = DEF_OUTW,
    parameter int NROWS     = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [INPUTSIZE-1:0]                         msg_in,
    input  logic                                         msgin_vld,
    output logic                                         msgin_rdy,
    input  logic                                         start,
    input  logic [NROWS*CHUNK*OUTW-1:0]                  randomin,
    input  logic                                         rnd_vld,
    output logic [clog2((INPUTSIZE+CHUNK-1)/CHUNK)-1:0] rnd_idx,
    output logic                                         busy,
`ifdef LBIROW_STALLCNT_EN
    output logic [15:0]                                  stall_cnt,
`endif
    output logic [NROWS*OUTW-1:0]                        msgrow_out,
    output logic                                         msgrowout_vld,
    input  logic                                         out_rdy
);

    localparam int ROUNDS = (INPUTSIZE + CHUNK - 1) / CHUNK;
    localparam int IDXW   = clog2(ROUNDS);
    localparam int MSGW   = ROUNDS * CHUNK;

    state_t state_q;
    state_t state_d;

    logic [MSGW-1:0]      msg_q;
    logic [IDXW-1:0]      idx_q;
    logic [OUTW-1:0]      sum_q  [NROWS];
    logic [OUTW-1:0]      sum_nx [NROWS];
    logic [OUTW-1:0]      part   [NROWS];
    logic [NROWS*OUTW-1:0] sum_pk;
    logic [CHUNK-1:0]     mask;

    logic go;
    logic take;
    logic last;

    assign go   = (state_q == IDLE) && start;
    assign take = (state_q == RUNNING) && rnd_vld;
    assign last = take && (idx_q == IDXW'(ROUNDS - 1));

    // Message bits of the round currently being consumed.
    assign mask = msg_q[idx_q*CHUNK +: CHUNK];

    for (genvar r = 0; r < NROWS; r++) begin : g_row
        lbi_adder_tree #(
            .CHUNK (CHUNK),
            .OUTW  (OUTW)
        ) u_tree (
            .mask   (mask),
            .leaves (randomin[r*CHUNK*OUTW +: CHUNK*OUTW]),
            .sum    (part[r])
        );
        assign sum_nx[r] = sum_q[r] + part[r];
    end

    // Pack the post-round sums into the output row layout.
    always_comb begin
        sum_pk = '0;
        for (int r = 0; r < NROWS; r++) begin
            sum_pk[r*OUTW +: OUTW] = sum_nx[r];
        end
    end

    // Next-state logic: IDLE -> RUNNING -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)   state_d = RUNNING;
            RUNNING: if (last)    state_d = DONE;
            DONE:    if (out_rdy) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Message capture, only while idle; upper pad bits stay zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_q <= '0;
        end else if ((state_q == IDLE) && msgin_vld) begin
            msg_q <= MSGW'(msg_in);
        end
    end

    // Row accumulators and round index; frozen while rnd_vld is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            for (int r = 0; r < NROWS; r++) begin
                sum_q[r] <= '0;
            end
        end else if (go) begin
            idx_q <= '0;
            for (int r = 0; r < NROWS; r++) begin
                sum_q[r] <= '0;
            end
        end else if (take) begin
            idx_q <= idx_q + 1'b1;
            for (int r = 0; r < NROWS; r++) begin
                sum_q[r] <= sum_nx[r];
            end
        end
    end

    // Result register: loaded with the final round, held until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msgrow_out    <= '0;
            msgrowout_vld <= 1'b0;
        end else if (last) begin
            msgrow_out    <= sum_pk;
            msgrowout_vld <= 1'b1;
        end else if ((state_q == DONE) && out_rdy) begin
            msgrowout_vld <= 1'b0;
        end
    end

`ifdef LBIROW_STALLCNT_EN
    logic [15:0] stall_q;

    // Count starved RUNNING cycles, saturating; held outside RUNNING.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (go) begin
            stall_q <= '0;
        end else if ((state_q == RUNNING) && !rnd_vld && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign msgin_rdy = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rnd_idx   = idx_q;

endmodule

// File: tb/tb_lbi_row_hash.sv
// tb_lbi_row_hash: randomized self-checking bench for lbi_row_hash.
// Expected rows come from a per-message-bit reference sum over the random slices.
module tb_lbi_row_hash;

    localparam int IN = 840;
    localparam int CH = 16;
    localparam int OW = 6;
    localparam int NR = 4;
    localparam int RD = 53;
    localparam int RW = NR * CH * OW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IN-1:0]     msg_in;
    logic              msgin_vld;
    logic              msgin_rdy;
    logic              start;
    logic [RW-1:0]     randomin;
    logic              rnd_vld;
    logic [5:0]        rnd_idx;
    logic              busy;
    logic [NR*OW-1:0]  msgrow_out;
    logic              msgrowout_vld;
    logic              out_rdy;
`ifdef LBIROW_STALLCNT_EN
    logic [15:0]       stall_cnt;
`endif

    logic [RW-1:0] rnd_mem [RD];
    int total = 0;
    int bad = 0;

    lbi_row_hash dut (
        .clk           (clk),
        .reset         (rst_n),
        .msg_in        (msg_in),
        .msgin_vld     (msgin_vld),
        .msgin_rdy     (msgin_rdy),
        .start         (start),
        .randomin      (randomin),
        .rnd_vld       (rnd_vld),
        .rnd_idx       (rnd_idx),
        .busy          (busy),
`ifdef LBIROW_STALLCNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .msgrow_out    (msgrow_out),
        .msgrowout_vld (msgrowout_vld),
        .out_rdy       (out_rdy)
    );

    always #5 clk = ~clk;

    // Random-matrix generator stand-in, addressed by the engine's round index.
    always_comb begin
        randomin = '0;
        if (rnd_idx < 6'(RD)) randomin = rnd_mem[rnd_idx];
    end

    function automatic logic [NR*OW-1:0] model(input logic [IN-1:0] m);
        logic [NR*OW-1:0] res;
        logic [RW-1:0] sl;
        int acc [NR];
        for (int r = 0; r < NR; r++) acc[r] = 0;
        for (int k = 0; k < IN; k++) begin
            if (m[k]) begin
                sl = rnd_mem[k / CH];
                for (int r = 0; r < NR; r++)
                    acc[r] += int'(sl[(r*CH + (k % CH))*OW +: OW]);
            end
        end
        res = '0;
        for (int r = 0; r < NR; r++) res[r*OW +: OW] = acc[r][OW-1:0];
        return res;
    endfunction

    function automatic logic [IN-1:0] rand_msg();
        logic [863:0] t;
        for (int w = 0; w < 27; w++) t[w*32 +: 32] = $urandom;
        return t[IN-1:0];
    endfunction

    task automatic fill_const(input logic [OW-1:0] v);
        for (int i = 0; i < RD; i++)
            for (int l = 0; l < NR*CH; l++) rnd_mem[i][l*OW +: OW] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < RD; i++)
            for (int w = 0; w < RW/32; w++) rnd_mem[i][w*32 +: 32] = $urandom;
    endtask

    task automatic do_job(input logic [IN-1:0] m, input bit load,
                          input int stall_at, input int stall_len, input bit rstall,
                          output int cyc, output int nstall, output bit to);
        int held;
        held = 0;
        nstall = 0;
        to = 0;
        @(negedge clk);
        msg_in = m;
        msgin_vld = load;
        start = 1;
        rnd_vld = 0;
        @(negedge clk);
        msgin_vld = 0;
        start = 0;
        cyc = 1;
        while (msgrowout_vld !== 1'b1 && cyc < 3000) begin
            if (int'(rnd_idx) == stall_at && held < stall_len) begin
                rnd_vld = 0;
                held++;
                nstall++;
            end else if (rstall && $urandom_range(0, 3) == 0) begin
                rnd_vld = 0;
                nstall++;
            end else begin
                rnd_vld = 1;
            end
            @(negedge clk);
            cyc++;
        end
        rnd_vld = 0;
        if (msgrowout_vld !== 1'b1) to = 1;
    endtask

    task automatic accept();
        @(negedge clk);
        out_rdy = 1;
        @(negedge clk);
        out_rdy = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        msg_in = '0;
        msgin_vld = 0;
        start = 0;
        rnd_vld = 0;
        out_rdy = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        total++; if (msgin_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", msgin_rdy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (msgrowout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", msgrowout_vld); end
        total++; if (msgrow_out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", msgrow_out); end
        total++; if (rnd_idx !== 6'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", rnd_idx); end
    endtask

    task automatic test_all_ones();
        int cyc, ns;
        bit to;
        logic [NR*OW-1:0] keep;
        fill_const(6'd1);
        do_job('1, 1, -1, 0, 0, cyc, ns, to);
        total++; if (to) begin bad++; $display("FAIL ones_timeout got=no_valid exp=valid"); end
        total++; if (cyc != 54) begin bad++; $display("FAIL ones_latency got=%0d exp=54", cyc); end
        total++; if (msgrow_out !== {NR{6'd8}}) begin bad++; $display("FAIL ones_rows got=%h exp=%h", msgrow_out, {NR{6'd8}}); end
        total++; if (busy !== 1'b1 || msgin_rdy !== 1'b0) begin bad++; $display("FAIL ones_done_flags got=%b%b exp=10", busy, msgin_rdy); end
        keep = msgrow_out;
        accept();
        total++; if (msgrowout_vld !== 1'b0 || busy !== 1'b0 || msgin_rdy !== 1'b1) begin
            bad++; $display("FAIL ones_accept got=%b%b%b exp=001", msgrowout_vld, busy, msgin_rdy); end
        total++; if (msgrow_out !== {NR{6'd8}}) begin bad++; $display("FAIL ones_hold got=%h exp=%h", msgrow_out, {NR{6'd8}}); end
        if (keep !== msgrow_out) ;
    endtask

    task automatic test_zero_msg();
        int cyc, ns;
        bit to;
        fill_const(6'd63);
        do_job('0, 1, -1, 0, 0, cyc, ns, to);
        total++; if (to || msgrow_out !== '0) begin bad++; $display("FAIL zero_rows got=%h exp=0 to=%0d", msgrow_out, to); end
        accept();
    endtask

    task automatic test_single_bit();
        int cyc, ns;
        bit to;
        logic [IN-1:0] m;
        logic [NR*OW-1:0] exp;
        fill_const(6'd0);
        rnd_mem[52][(0*CH + 7)*OW +: OW] = 6'd5;
        rnd_mem[52][(1*CH + 7)*OW +: OW] = 6'd63;
        m = '0;
        m[839] = 1'b1;
        exp = {6'd0, 6'd0, 6'd63, 6'd5};
        do_job(m, 1, -1, 0, 0, cyc, ns, to);
        total++; if (to || msgrow_out !== exp) begin bad++; $display("FAIL bit839_rows got=%h exp=%h", msgrow_out, exp); end
        accept();
    endtask

    task automatic test_stall();
        int cyc, ns;
        bit to;
        fill_const(6'd1);
        do_job('1, 1, 20, 10, 0, cyc, ns, to);
        total++; if (to || cyc != 64) begin bad++; $display("FAIL stall_latency got=%0d exp=64", cyc); end
        total++; if (msgrow_out !== {NR{6'd8}}) begin bad++; $display("FAIL stall_rows got=%h exp=%h", msgrow_out, {NR{6'd8}}); end
`ifdef LBIROW_STALLCNT_EN
        total++; if (stall_cnt !== 16'd10) begin bad++; $display("FAIL stall_cnt got=%0d exp=10", stall_cnt); end
`endif
        accept();
`ifdef LBIROW_STALLCNT_EN
        total++; if (stall_cnt !== 16'd10) begin bad++; $display("FAIL stall_cnt_hold got=%0d exp=10", stall_cnt); end
`endif
    endtask

    task automatic test_done_hold();
        int cyc, ns;
        bit to;
        logic [IN-1:0] m1;
        logic [NR*OW-1:0] exp;
        fill_rand();
        m1 = rand_msg();
        exp = model(m1);
        do_job(m1, 1, -1, 0, 0, cyc, ns, to);
        total++; if (to || msgrow_out !== exp) begin bad++; $display("FAIL hold_rows got=%h exp=%h", msgrow_out, exp); end
        for (int i = 0; i < 5; i++) begin
            out_rdy = 0;
            start = 1'(i % 2);
            msgin_vld = 1;
            msg_in = ~m1;
            @(negedge clk);
            total++; if (msgrowout_vld !== 1'b1 || msgrow_out !== exp || msgin_rdy !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL hold_cycle%0d got=%b%b%b/%h exp=101/%h", i, msgrowout_vld, msgin_rdy, busy, msgrow_out, exp); end
        end
        start = 0;
        msgin_vld = 0;
        out_rdy = 1;
        @(negedge clk);
        out_rdy = 0;
        total++; if (msgrowout_vld !== 1'b0 || msgin_rdy !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL hold_release got=%b%b%b exp=010", msgrowout_vld, msgin_rdy, busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_start_ignored got=%b exp=0", busy); end
        do_job(~m1, 0, -1, 0, 0, cyc, ns, to);
        total++; if (to || msgrow_out !== exp) begin bad++; $display("FAIL hold_msg_kept got=%h exp=%h", msgrow_out, exp); end
        accept();
    endtask

    task automatic test_reset_mid();
        int cyc, ns, guard;
        bit to;
        logic [IN-1:0] m;
        fill_rand();
        @(negedge clk);
        msg_in = rand_msg();
        msgin_vld = 1;
        start = 1;
        @(negedge clk);
        msgin_vld = 0;
        start = 0;
        rnd_vld = 1;
        guard = 0;
        while (rnd_idx !== 6'd30 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++; if (guard >= 100) begin bad++; $display("FAIL rstmid_reach got=%0d exp=30", rnd_idx); end
        rst_n = 0;
        rnd_vld = 0;
        #1;
        total++; if (busy !== 1'b0 || msgin_rdy !== 1'b1 || msgrowout_vld !== 1'b0) begin
            bad++; $display("FAIL rstmid_flags got=%b%b%b exp=010", busy, msgin_rdy, msgrowout_vld); end
        total++; if (msgrow_out !== '0 || rnd_idx !== 6'd0) begin
            bad++; $display("FAIL rstmid_out got=%h idx=%0d exp=0", msgrow_out, rnd_idx); end
        @(negedge clk);
        rst_n = 1;
        m = rand_msg();
        do_job(m, 1, -1, 0, 0, cyc, ns, to);
        total++; if (to || cyc != 54 || msgrow_out !== model(m)) begin
            bad++; $display("FAIL rstmid_rerun got=%h/%0d exp=%h/54", msgrow_out, cyc, model(m)); end
        accept();
    endtask

    task automatic test_back_to_back();
        int cyc, ns;
        bit to;
        logic [IN-1:0] m;
        for (int n = 0; n < 6; n++) begin
            fill_rand();
            m = rand_msg();
            do_job(m, 1, -1, 0, 1, cyc, ns, to);
            total++; if (to || msgrow_out !== model(m)) begin
                bad++; $display("FAIL rand%0d_rows got=%h exp=%h", n, msgrow_out, model(m)); end
            total++; if (cyc != 54 + ns) begin
                bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, cyc, 54 + ns); end
`ifdef LBIROW_STALLCNT_EN
            total++; if (int'(stall_cnt) != ns) begin
                bad++; $display("FAIL rand%0d_stall_cnt got=%0d exp=%0d", n, stall_cnt, ns); end
`endif
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_zero_msg();
        test_single_bit();
        test_stall();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lbi_row_hash.md
Name: lbi_row_hash

Overview:
- Multi-row, parametrised LBI row-hash engine.
- Latches one message, then streams it CHUNK bits per round against a per-round random matrix slice.
- Accumulates NROWS independent OUTW-bit (mod 2^OUTW) dot products in parallel.
- Sits between the message loader and the random-matrix generator; results go to the signature packer over a valid/ready handshake.

Parameters:
- INPUTSIZE, 840: message width in bits.
- CHUNK, 16: message bits consumed per round.
- OUTW, 6: accumulator/result width; all arithmetic is mod 2^OUTW.
- NROWS, 4: matrix rows computed in parallel.
- ROUNDS, ceil(INPUTSIZE/CHUNK) = 53: derived localparam, not overridable.
- RANDW, NROWS*CHUNK*OUTW = 384: derived localparam.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- msg_in  in  INPUTSIZE  message to hash.
- msgin_vld  in  1  message valid.
- msgin_rdy  out  1  high only in IDLE; message captured on msgin_vld & msgin_rdy.
- start  in  1  begin hashing the stored message; honoured only in IDLE.
- randomin  in  RANDW  random slice for current round; leaf (r,j) = randomin[(r*CHUNK+j)*OUTW +: OUTW].
- rnd_vld  in  1  randomin valid this cycle.
- rnd_idx  out  clog2(ROUNDS)  round index being consumed (addresses the random generator).
- busy  out  1  high in RUNNING and DONE.
- msgrow_out  out  NROWS*OUTW  row r result at [r*OUTW +: OUTW].
- msgrowout_vld  out  1  result valid; held until accepted.
- out_rdy  in  1  downstream accept.

Behaviour:
- Reset (async, active-low): state IDLE; message register, sums, round counter, msgrow_out, msgrowout_vld and busy all 0; msgin_rdy=1. Reset mid-run aborts with no output.
- Message register: INPUTSIZE bits, zero-padded to ROUNDS*CHUNK. Loaded when msgin_vld in IDLE; msgin_vld in other states is ignored.
- States:
  - IDLE: on start, go to RUNNING; clear all sums and round counter to 0. If msgin_vld and start occur in the same cycle, the new message is used.
  - RUNNING: when rnd_vld=1, for every row r, sum_r += Σ_j msgbit[idx*CHUNK+j] ? leaf(r,j) : 0, mod 2^OUTW, and idx increments. When rnd_vld=0 (stall), nothing changes. After consuming round ROUNDS-1, go to DONE.
  - DONE: msgrow_out = sums (registered); msgrowout_vld=1. On out_rdy, go to IDLE and deassert valid next cycle. msgrow_out keeps its last value afterwards.
- Latency: start at cycle 0 with no stalls → rounds consumed in cycles 1..ROUNDS; msgrowout_vld high from cycle ROUNDS+1 (54). Each stall cycle adds 1.
- start outside IDLE is ignored and not queued.
- Adder tree is combinational, with CHUNK leaves per row. Intermediate widths are truncated to OUTW; this is legal because the result is mod 2^OUTW.
- CHUNK need not be a power of two: the tree pads missing leaves with 0.

Optional Feature:
- Macro LBIROW_STALLCNT_EN.
- Defined: adds output stall_cnt[15:0]. It clears at start, increments each RUNNING cycle with rnd_vld=0, saturates at 16'hFFFF, and is held through DONE/IDLE.
- Undefined: no port and no counter logic.

Decomposition:
- Package lbi_pkg:
  - state encoding constants IDLE/RUNNING/DONE;
  - clog2 function;
  - default CHUNK/OUTW constants.
- Sub-module lbi_adder_tree (CHUNK, OUTW):
  - inputs: CHUNK mask bits and CHUNK*OUTW leaves;
  - output: OUTW-bit sum;
  - instantiated NROWS times in a generate loop.

Test Plan:
- All-ones message, every leaf=1, rnd_vld always 1 → every row = 840 mod 64 = 8; msgrowout_vld rises 54 cycles after start.
- All-zero message, random leaves all 63 → all rows 0.
- Only bit 839 set; round-52 leaf j=7 = 5 (row0) and 63 (row1), other leaves 0 → row0=5, row1=63, rows2-3=0.
- Case 1 with rnd_vld low for 10 cycles during round 20 → identical results; valid at cycle 64; stall_cnt=10 when LBIROW_STALLCNT_EN is defined.
- out_rdy held low 5 cycles in DONE; start and msgin_vld pulsed meanwhile → output stable, valid held, msgin_rdy=0, start ignored; IDLE one cycle after out_rdy.
- reset driven to 0 at round 30 → outputs immediately 0, busy=0, msgin_rdy=1; new run after release yields the correct result.
